ic_fetch_queue: RTL and testbench

//  Parametrised fetch queue between the PC stage and ID; replaces the single IF/ID register.

---
 rtl/ic_fetch_queue.sv | 93 +++++++++
 tb/tb_ic_fetch_queue.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ic_fetch_queue.sv
// Fetch queue between the PC stage and ID: circular FIFO of {ce,pc} entries with
// valid/ready on both sides. Optional zero-latency empty-queue bypass under IC_FQ_BYPASS_EN.
module ic_fetch_queue #(
  parameter int unsigned PC_WD = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           br_e,
  input  logic                           in_valid,
  input  logic                           in_ce,
  input  logic [PC_WD-1:0]               in_pc,
  output logic                           in_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PC_WD:0]                 out_bus,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_WD = $clog2(DEPTH);
  localparam int unsigned CNT_WD = $clog2(DEPTH + 1);

  // Stored entries always have ce=1, so only the PC is kept.
  logic [PC_WD-1:0]  r_mem [DEPTH];
  logic [PTR_WD-1:0] r_rd_ptr;
  logic [PTR_WD-1:0] r_wr_ptr;
  logic [CNT_WD-1:0] r_count;

  logic w_kill;
  logic w_empty;
  logic w_full;
  logic w_acc;
  logic w_byp;
  logic w_enq;
  logic w_deq;

  always_comb begin
    w_kill   = flush | br_e;
    w_empty  = (r_count == '0);
    w_full   = (r_count == CNT_WD'(DEPTH));
    in_ready = rst & ~w_full & ~w_kill;
    w_acc    = in_valid & in_ready & in_ce;
`ifdef IC_FQ_BYPASS_EN
    w_byp    = w_empty & w_acc;
`else
    w_byp    = 1'b0;
`endif
    out_valid = (~w_empty | w_byp) & ~w_kill;
    if (!out_valid) begin
      out_bus = '0;
    end else if (w_byp) begin
      out_bus = {1'b1, in_pc};
    end else begin
      out_bus = {1'b1, r_mem[r_rd_ptr]};
    end
    // A bypassed entry consumed the same cycle never touches storage.
    w_deq = out_valid & out_ready & ~w_empty;
    w_enq = w_acc & ~(w_byp & out_ready);
    count = r_count;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_kill) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_wr_ptr <= r_wr_ptr + PTR_WD'(1);
      end
      if (w_deq) begin
        r_rd_ptr <= r_rd_ptr + PTR_WD'(1);
      end
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CNT_WD'(1);
        2'b01:   r_count <= r_count - CNT_WD'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_mem[r_wr_ptr] <= in_pc;
    end
  end

endmodule

// File: tb/tb_ic_fetch_queue.sv
// Scoreboard bench for ic_fetch_queue; expectations adapt to IC_FQ_BYPASS_EN.
module tb_ic_fetch_queue;

  localparam int unsigned PC_WD = 32;
  localparam int unsigned DEPTH = 4;
`ifdef IC_FQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              br_e;
  logic              in_valid;
  logic              in_ce;
  logic [PC_WD-1:0]  in_pc;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [PC_WD:0]    out_bus;
  logic [2:0]        count;

  logic [PC_WD:0] exp_q[$];
  int vectors    = 0;
  int miscompares = 0;

  ic_fetch_queue #(.PC_WD(PC_WD), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .br_e      (br_e),
    .in_valid  (in_valid),
    .in_ce     (in_ce),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bus   (out_bus),
    .count     (count)
  );

  always #5 clk = ~clk;

  function automatic bit exp_ready();
    return rst && (exp_q.size() != DEPTH) && !flush && !br_e;
  endfunction

  function automatic bit exp_byp();
    return BYP && rst && (exp_q.size() == 0) && in_valid && in_ce && !flush && !br_e;
  endfunction

  function automatic bit exp_valid();
    return rst && !flush && !br_e && ((exp_q.size() != 0) || exp_byp());
  endfunction

  function automatic logic [PC_WD:0] exp_bus();
    if (!exp_valid()) return '0;
    if (exp_q.size() == 0) return {1'b1, in_pc};
    return exp_q[0];
  endfunction

  // Advance the reference queue with the inputs the DUT samples this edge, then clock.
  task automatic tick();
    bit acc, deq;
    if (!rst || flush || br_e) begin
      exp_q.delete();
    end else begin
      acc = in_valid && in_ce && exp_ready();
      deq = out_ready && exp_valid();
      if (acc) exp_q.push_back({1'b1, in_pc});
      if (deq) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 0; br_e = 0; in_valid = 0; in_ce = 0; in_pc = '0; out_ready = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    #1 rst = 0;
    #1;
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_bus !== '0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got cnt=%0d v=%0b bus=%h rdy=%0b want 0/0/0/0",
               count, out_valid, out_bus, in_ready);
    end
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%0b cnt=%0d want 1/0", in_ready, count);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_ce = 1; in_pc = 32'h0000_0040 + 32'(4 * i);
      @(negedge clk);
      vectors++;
      if (in_ready !== exp_ready() || count !== 3'(exp_q.size())) begin
        miscompares++;
        $display("FAIL reset_fill: got rdy=%0b cnt=%0d want %0b/%0d",
                 in_ready, count, exp_ready(), exp_q.size());
      end
      tick();
    end
    in_valid = 0;
    #1 rst = 0;
    #1;
    exp_q.delete();
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_bus !== '0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got cnt=%0d v=%0b bus=%h rdy=%0b want 0/0/0/0",
               count, out_valid, out_bus, in_ready);
    end
    @(posedge clk); #1 rst = 1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_release: got rdy=%0b v=%0b want 1/0", in_ready, out_valid);
    end
    tick();
  endtask

  task automatic test_fill_drain();
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_ce = 1; in_pc = 32'hBFC0_0000 + 32'(4 * i);
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b1 || out_valid !== exp_valid() || out_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL fill_push%0d: got rdy=%0b v=%0b bus=%h want 1/%0b/%h",
                 i, in_ready, out_valid, out_bus, exp_valid(), exp_bus());
      end
      tick();
    end
    in_pc = 32'hDEAD_0000;  // offered while full, must be refused
    @(negedge clk);
    vectors++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: got cnt=%0d rdy=%0b want 4/0", count, in_ready);
    end
    tick();
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_bus !== {1'b1, 32'hBFC0_0000 + 32'(4 * i)} ||
          out_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL drain%0d: got v=%0b bus=%h want 1/%h", i, out_valid, out_bus,
                 {1'b1, 32'hBFC0_0000 + 32'(4 * i)});
      end
      tick();
    end
    @(negedge clk);
    vectors++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_bus !== '0) begin
      miscompares++;
      $display("FAIL drain_empty: got cnt=%0d v=%0b bus=%h want 0/0/0", count, out_valid, out_bus);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_simultaneous();
    logic [PC_WD:0] seen [3];
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_ce = 1; in_pc = 32'h0000_00A0 + 32'(4 * i);
      tick();
    end
    in_pc = 32'h0000_0100; out_ready = 1;
    @(negedge clk);
    vectors++;
    if (count !== 3'd2 || out_bus !== exp_bus()) begin
      miscompares++;
      $display("FAIL simul_pre: got cnt=%0d bus=%h want 2/%h", count, out_bus, exp_bus());
    end
    seen[0] = out_bus;
    tick();
    in_valid = 0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd2) begin
      miscompares++;
      $display("FAIL simul_count: got %0d want 2", count);
    end
    for (int i = 1; i < 3; i++) begin
      if (i > 1) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL simul_out%0d: got v=%0b bus=%h want 1/%h", i, out_valid, out_bus, exp_bus());
      end
      seen[i] = out_bus;
      tick();
    end
    vectors++;
    if (seen[2] !== {1'b1, 32'h0000_0100}) begin
      miscompares++;
      $display("FAIL simul_third: got %h want %h", seen[2], {1'b1, 32'h0000_0100});
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_flush();
    for (int k = 0; k < 2; k++) begin
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
        in_valid = 1; in_ce = 1; in_pc = 32'h0000_0500 + 32'(4 * i);
        tick();
      end
      in_pc = 32'h0000_0200;
      if (k == 0) br_e = 1; else flush = 1;
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd3) begin
        miscompares++;
        $display("FAIL kill%0d_cycle: got v=%0b rdy=%0b cnt=%0d want 0/0/3",
                 k, out_valid, in_ready, count);
      end
      tick();
      idle_inputs();
      out_ready = 1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        vectors++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_bus !== '0) begin
          miscompares++;
          $display("FAIL kill%0d_after%0d: got cnt=%0d v=%0b bus=%h want 0/0/0",
                   k, c, count, out_valid, out_bus);
        end
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_bubble();
    int i = 0;
    int n_out = 0;
    int cycles = 0;
    bit acc;
    idle_inputs();
    while (i < 10 && cycles < 200) begin
      in_valid = 1; in_ce = (i % 3 != 2); in_pc = 32'h0000_1000 + 32'(4 * i);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = exp_ready();
      vectors++;
      if (in_ready !== acc || count !== 3'(exp_q.size()) || count > 3'd4 ||
          out_valid !== exp_valid() || out_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL wrap_c%0d: got rdy=%0b cnt=%0d v=%0b bus=%h want %0b/%0d/%0b/%h",
                 cycles, in_ready, count, out_valid, out_bus, acc, exp_q.size(),
                 exp_valid(), exp_bus());
      end
      if (out_valid && out_ready) n_out++;
      tick();
      if (acc) i++;
      cycles++;
    end
    in_valid = 0; out_ready = 1;
    cycles = 0;
    while (exp_q.size() != 0 && cycles < 20) begin
      @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_bus !== exp_bus()) begin
        miscompares++;
        $display("FAIL wrap_drain%0d: got v=%0b bus=%h want 1/%h", cycles, out_valid, out_bus,
                 exp_bus());
      end
      if (out_valid && out_ready) n_out++;
      tick();
      cycles++;
    end
    vectors++;
    if (i != 10 || exp_q.size() != 0 || n_out != 7) begin
      miscompares++;
      $display("FAIL wrap_total: got offered=%0d left=%0d outs=%0d want 10/0/7",
               i, exp_q.size(), n_out);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_bypass();
    idle_inputs();
    in_valid = 1; in_ce = 1; in_pc = 32'h0000_0300; out_ready = 1;
    @(negedge clk);
    vectors++;
    if (out_valid !== BYP || out_bus !== (BYP ? {1'b1, 32'h0000_0300} : 33'd0)) begin
      miscompares++;
      $display("FAIL byp_same: got v=%0b bus=%h want %0b/%h", out_valid, out_bus, BYP,
               BYP ? {1'b1, 32'h0000_0300} : 33'd0);
    end
    tick();
    in_valid = 0;
    @(negedge clk);
    vectors++;
    if (count !== (BYP ? 3'd0 : 3'd1) || out_valid !== !BYP ||
        out_bus !== (BYP ? 33'd0 : {1'b1, 32'h0000_0300})) begin
      miscompares++;
      $display("FAIL byp_next: got cnt=%0d v=%0b bus=%h want %0d/%0b", count, out_valid, out_bus,
               BYP ? 0 : 1, !BYP);
    end
    tick();
    @(negedge clk);
    vectors++;
    if (count !== 3'd0) begin
      miscompares++;
      $display("FAIL byp_empty: got cnt=%0d want 0", count);
    end
    tick();
    in_valid = 1; in_ce = 1; in_pc = 32'h0000_0304; out_ready = 0;
    @(negedge clk);
    vectors++;
    if (out_valid !== BYP || out_bus !== exp_bus()) begin
      miscompares++;
      $display("FAIL byp_stall: got v=%0b bus=%h want %0b/%h", out_valid, out_bus, BYP, exp_bus());
    end
    tick();
    in_valid = 0;
    @(negedge clk);
    vectors++;
    if (count !== 3'd1 || out_valid !== 1'b1 || out_bus !== {1'b1, 32'h0000_0304}) begin
      miscompares++;
      $display("FAIL byp_stored: got cnt=%0d v=%0b bus=%h want 1/1/%h", count, out_valid, out_bus,
               {1'b1, 32'h0000_0304});
    end
    out_ready = 1;
    tick();
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_flush();
    test_wrap_bubble();
    test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
